// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin arbiter that turns column-byte writes into KS0108-style LCD command/data bytes
//   clk, rstn                : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  : per-requester write request / one-cycle accept pulse
//   req_page_i/col_i/data_i  : packed per-requester page (3b), column (7b), byte (8b)
//   lcd_valid_o/lcd_ready_i  : registered byte stream to the bus driver
//   lcd_dori_o, lcd_cs_o, lcd_db_o : data/instruction flag, chip select, byte value
//   busy_o                   : high whenever the FSM is not IDLE
//   LCD_ARB_ADDR_CACHE_EN    : when defined, a per-chip page/y cache skips redundant address bytes
module lcd_write_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NREQ-1:0]     req_valid_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic [3*NREQ-1:0]   req_page_i,
  input  logic [7*NREQ-1:0]   req_col_i,
  input  logic [8*NREQ-1:0]   req_data_i,
  output logic                lcd_valid_o,
  input  logic                lcd_ready_i,
  output logic                lcd_dori_o,
  output logic [1:0]          lcd_cs_o,
  output logic [7:0]          lcd_db_o,
  output logic                busy_o
);
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SET_PAGE, S_SET_COL, S_WRITE} state_t;
  state_t r_state, w_next, w_first, w_after_page;
  logic [LW-1:0] r_last, w_gnt;
  logic w_found, w_hs, w_take;
  logic [2:0] r_page, w_page, w_lpage;
  logic [6:0] r_col, w_col, w_lcol;
  logic [7:0] r_data, w_data, w_ldata;
  logic r_lcd_valid, r_lcd_dori, r_busy;
  logic [1:0] r_lcd_cs;
  logic [7:0] r_lcd_db;
  logic w_valid_n, w_dori_n;
  logic [1:0] w_cs_n;
  logic [7:0] w_db_n;
  logic [NREQ-1:0] w_ready;
  assign w_hs   = r_lcd_valid & lcd_ready_i;
  assign w_take = (r_state == S_IDLE) & w_found;
  // search starts one past the last grant so every requester gets its turn
  always_comb begin
    int j;
    j = 0;
    w_found = 1'b0;
    w_gnt = '0;
    w_page = '0;
    w_col = '0;
    w_data = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(r_last) + i) % NREQ;
      if (!w_found && (req_valid_i & (NREQ'(1) << j)) != '0) begin
        w_found = 1'b1;
        w_gnt = LW'(j);
        w_page = 3'(req_page_i >> (3 * j));
        w_col = 7'(req_col_i >> (7 * j));
        w_data = 8'(req_data_i >> (8 * j));
      end
    end
  end
`ifdef LCD_ARB_ADDR_CACHE_EN
  logic [1:0] r_cv;
  logic [2:0] r_cpage [2];
  logic [5:0] r_cy [2];
  logic w_hp, w_hy, w_hy_l;
  // page and y are independent LCD registers, so each can be skipped on its own
  always_comb begin
    w_hp = r_cv[w_col[6]] && (r_cpage[w_col[6]] == w_page);
    w_hy = r_cv[w_col[6]] && (r_cy[w_col[6]] == w_col[5:0]);
    w_hy_l = r_cv[r_col[6]] && (r_cy[r_col[6]] == r_col[5:0]);
    w_first = !w_hp ? S_SET_PAGE : (w_hy ? S_WRITE : S_SET_COL);
    w_after_page = w_hy_l ? S_WRITE : S_SET_COL;
  end
  // the chip auto-increments y after each data byte; 6-bit add wraps 63 -> 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cv <= '0;
      r_cpage <= '{default: '0};
      r_cy <= '{default: '0};
    end else if (r_state == S_WRITE && w_hs) begin
      r_cv[r_col[6]] <= 1'b1;
      r_cpage[r_col[6]] <= r_page;
      r_cy[r_col[6]] <= r_col[5:0] + 6'd1;
    end
  end
`else
  assign w_first = S_SET_PAGE;
  assign w_after_page = S_SET_COL;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_INIT;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:     w_next = w_hs ? S_IDLE : S_INIT;
      S_IDLE:     w_next = w_found ? w_first : S_IDLE;
      S_SET_PAGE: w_next = w_hs ? w_after_page : S_SET_PAGE;
      S_SET_COL:  w_next = w_hs ? S_WRITE : S_SET_COL;
      S_WRITE:    w_next = w_hs ? S_IDLE : S_WRITE;
      default:    w_next = S_INIT;
    endcase
  end
  // output values are computed for the upcoming state and captured in flops
  always_comb begin
    w_lpage = w_take ? w_page : r_page;
    w_lcol = w_take ? w_col : r_col;
    w_ldata = w_take ? w_data : r_data;
    w_valid_n = w_next != S_IDLE;
    w_dori_n = w_next == S_WRITE;
    w_cs_n = (w_next == S_INIT) ? 2'b11 : (w_lcol[6] ? 2'b10 : 2'b01);
    w_db_n = (w_next == S_INIT)     ? 8'h3F :
             (w_next == S_SET_PAGE) ? {5'b10111, w_lpage} :
             (w_next == S_SET_COL)  ? {2'b01, w_lcol[5:0]} :
             (w_next == S_WRITE)    ? w_ldata : 8'h00;
    w_ready = w_take ? (NREQ'(1) << w_gnt) : '0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last <= LW'(NREQ - 1);
      r_page <= '0;
      r_col <= '0;
      r_data <= '0;
      r_lcd_valid <= 1'b1;
      r_lcd_dori <= 1'b0;
      r_lcd_cs <= 2'b11;
      r_lcd_db <= 8'h3F;
      r_busy <= 1'b1;
    end else begin
      if (w_take) r_last <= w_gnt;
      r_page <= w_lpage;
      r_col <= w_lcol;
      r_data <= w_ldata;
      r_lcd_valid <= w_valid_n;
      r_lcd_dori <= w_dori_n;
      r_lcd_cs <= w_cs_n;
      r_lcd_db <= w_db_n;
      r_busy <= w_next != S_IDLE;
    end
  end
  assign req_ready_o = w_ready;
  assign lcd_valid_o = r_lcd_valid;
  assign lcd_dori_o = r_lcd_dori;
  assign lcd_cs_o = r_lcd_cs;
  assign lcd_db_o = r_lcd_db;
  assign busy_o = r_busy;
endmodule
